// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with a valid/ready byte handshake and a one-cycle done pulse per frame.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1) before the stop bit(s).
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 217,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

  // Reject configurations the frame timing cannot represent.
  if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_serializer: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             serial_q;
  logic             ready_q;
  logic             active_q;
  logic             done_q;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  assign bit_end = (clk_cnt == LAST_CNT);

  // bit_idx counts data bits in DATA and stop bits in STOP; the serial line is
  // always loaded one cycle ahead so it changes exactly on the bit boundary.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      serial_q  <= 1'b1;
      ready_q   <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state != IDLE) begin
        clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (i_TX_DV) begin
            state     <= START;
            shift_reg <= i_TX_Byte;
            serial_q  <= 1'b0;
            ready_q   <= 1'b0;
            active_q  <= 1'b1;
            clk_cnt   <= '0;
            bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= (^i_TX_Byte) ^ (PARITY_ODD != 0);
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state     <= DATA;
            serial_q  <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
              state    <= PARITY;
              serial_q <= parity_q;
`else
              state    <= STOP;
              serial_q <= 1'b1;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              serial_q  <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            serial_q <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (bit_idx == LAST_STOP) begin
              state    <= IDLE;
              bit_idx  <= '0;
              ready_q  <= 1'b1;
              active_q <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          serial_q <= 1'b1;
          ready_q  <= 1'b1;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_TX_Ready  = ready_q;
  assign o_TX_Active = active_q;
  assign o_TX_Serial = serial_q;
  assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: per-cycle waveform model plus a UART receive
// scoreboard on the main instance; a second instance covers two stop bits and odd parity.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       dv1, dv2;
  logic [7:0] byte1, byte2;
  logic       ready1, active1, serial1, done1;
  logic       ready2, active2, serial2, done2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_DV(dv1), .i_TX_Byte(byte1),
    .o_TX_Ready(ready1), .o_TX_Active(active1), .o_TX_Serial(serial1), .o_TX_Done(done1)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_DV(dv2), .i_TX_Byte(byte2),
    .o_TX_Ready(ready2), .o_TX_Active(active2), .o_TX_Serial(serial2), .o_TX_Done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx_byte;
    logic [7:0] noise;
    bit         hold;
    logic       par_even;
    int         gap;
  } vec_t;

  vec_t tbl[8];

  task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit sel2, input logic dv, input logic [7:0] b);
    if (sel2) begin
      dv2 = dv;
      byte2 = b;
    end else begin
      dv1 = dv;
      byte1 = b;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic expSerial(input logic [7:0] b, input logic par, input int k);
    int slot;
    if (k < 1) return 1'b1;
    slot = (k - 1) / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (PAR == 1 && slot == 9) return par;
    return 1'b1;
  endfunction

  task automatic checkIdle(input bit sel2, input string tag);
    checkOutput({tag, " serial"}, {8'h0, sel2 ? serial2 : serial1}, 9'h1);
    checkOutput({tag, " ready"},  {8'h0, sel2 ? ready2  : ready1},  9'h1);
    checkOutput({tag, " active"}, {8'h0, sel2 ? active2 : active1}, 9'h0);
    checkOutput({tag, " done"},   {8'h0, sel2 ? done2   : done1},   9'h0);
  endtask

  // Accepts b in the current cycle and checks every cycle through the done cycle;
  // returns in the done cycle (or the cycle after an abort) so callers can chain frames.
  task automatic runFrame(input bit sel2, input logic [7:0] b, input logic [7:0] noise,
                          input bit hold, input logic par, input int abort_at);
    int total;
    total = (10 + (sel2 ? 1 : 0) + PAR) * CPB;
    applyStimulus(sel2, 1'b1, b);
    checkOutput($sformatf("ready accept %0h", b), {8'h0, sel2 ? ready2 : ready1}, 9'h1);
    if (!sel2) exp_q.push_back({par, b});
    for (int k = 1; k <= total + 1; k++) begin
      step();
      if (k == abort_at + 1) begin
        rst_n = 1'b1;
        applyStimulus(sel2, 1'b0, 8'h00);
        checkIdle(sel2, "after abort");
        if (!sel2) exp_q.delete();
        return;
      end
      rst_n = (k == abort_at) ? 1'b0 : 1'b1;
      applyStimulus(sel2, hold && k <= total, noise);
      checkOutput($sformatf("serial %0h k=%0d", b, k), {8'h0, sel2 ? serial2 : serial1}, {8'h0, expSerial(b, par, k)});
      checkOutput($sformatf("active %0h k=%0d", b, k), {8'h0, sel2 ? active2 : active1}, {8'h0, k <= total});
      checkOutput($sformatf("ready %0h k=%0d", b, k),  {8'h0, sel2 ? ready2 : ready1},   {8'h0, k > total});
      checkOutput($sformatf("done %0h k=%0d", b, k),   {8'h0, sel2 ? done2 : done1},     {8'h0, k == total + 1});
    end
  endtask

  // Receive-side scoreboard: decodes the main instance's line at mid-bit and pops the expected byte.
  bit         rx_busy = 1'b0;
  int         rx_cnt  = 0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_par  = 1'b0;
  logic [8:0] rx_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_busy = 1'b0;
      rx_cnt  = 0;
    end else if (!rx_busy) begin
      if (serial1 == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        if (rx_cnt / CPB == 0) checkOutput("rx start bit", {8'h0, serial1}, 9'h0);
        else if (rx_cnt / CPB <= 8) rx_byte[rx_cnt / CPB - 1] = serial1;
        else if (PAR == 1 && rx_cnt / CPB == 9) rx_par = serial1;
        else begin
          checkOutput("rx stop bit", {8'h0, serial1}, 9'h1);
          if (exp_q.size() == 0) begin
            checkOutput("rx unexpected frame", {1'b0, rx_byte}, 9'h1FF);
          end else begin
            rx_exp = exp_q.pop_front();
            if (PAR == 1) checkOutput("rx byte+parity", {rx_par, rx_byte}, rx_exp);
            else          checkOutput("rx byte", {1'b0, rx_byte}, {1'b0, rx_exp[7:0]});
          end
          rx_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    tbl[0] = '{8'hA5, 8'h00, 1'b0, 1'b0, 2};
    tbl[1] = '{8'h3C, 8'hFF, 1'b1, 1'b0, 0};
    tbl[2] = '{8'h81, 8'h00, 1'b0, 1'b0, 3};
    tbl[3] = '{8'h01, 8'h7E, 1'b1, 1'b1, 0};
    tbl[4] = '{8'h80, 8'h55, 1'b1, 1'b1, 0};
    tbl[5] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1};
    tbl[6] = '{8'hC3, 8'h3C, 1'b1, 1'b0, 0};
    tbl[7] = '{8'h7F, 8'h80, 1'b1, 1'b1, 2};

    rst_n = 1'b0;
    dv1 = 1'b0; byte1 = 8'h00;
    dv2 = 1'b0; byte2 = 8'h00;
    repeat (3) step();
    checkIdle(1'b0, "in reset");
    checkIdle(1'b1, "in reset dut2");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkIdle(1'b0, $sformatf("post reset %0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      runFrame(1'b0, tbl[i].tx_byte, tbl[i].noise, tbl[i].hold, tbl[i].par_even, -10);
      for (int g = 0; g < tbl[i].gap; g++) begin
        step();
        checkIdle(1'b0, $sformatf("gap after %0h", tbl[i].tx_byte));
      end
    end

    runFrame(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 20);
    runFrame(1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, -10);
    step();
    checkIdle(1'b0, "after 5A");

    runFrame(1'b1, 8'h55, 8'h00, 1'b0, 1'b1, -10);
    step();
    checkIdle(1'b1, "dut2 after 55");
    runFrame(1'b1, 8'h01, 8'hFE, 1'b1, 1'b0, -10);
    step();
    checkIdle(1'b1, "dut2 after 01");

    repeat (4) step();
    checkOutput("scoreboard drained", 9'(exp_q.size()), 9'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
